hachure_wb_gpio: RTL

- Wishbone-classic slave GPIO peripheral inside hachure_soc.
- Drives the per-pin gpo/gpeo/gpcs/gpsl/gppu/gppd vectors routed to the GPIO bidir pads, and samples gpi from those pads.
- Synchronises pad inputs with a 2-FF chain, detects rising/falling edges and latches them into a write-1-to-clear status register.
- Raises a level interrupt when any enabled status bit is set.

---
 rtl/hachure_pkg.sv | 24 ++
 rtl/hachure_wb_gpio_if.sv | 29 ++
 rtl/hachure_sync2.sv | 32 +++
 rtl/hachure_wb_gpio.sv | 139 +++++++++++++
 4 files changed

// File: rtl/hachure_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hachure_pkg
// Description : Shared register map and reset constants for the hachure GPIO.
// Revision    : 1.0 - initial release
// ============================================================================
package hachure_pkg;

    localparam logic [3:0] GPIO_OUT     = 4'd0;
    localparam logic [3:0] GPIO_OE      = 4'd1;
    localparam logic [3:0] GPIO_IN      = 4'd2;
    localparam logic [3:0] GPIO_CS      = 4'd3;
    localparam logic [3:0] GPIO_SL      = 4'd4;
    localparam logic [3:0] GPIO_PU      = 4'd5;
    localparam logic [3:0] GPIO_PD      = 4'd6;
    localparam logic [3:0] GPIO_RISE_EN = 4'd7;
    localparam logic [3:0] GPIO_FALL_EN = 4'd8;
    localparam logic [3:0] GPIO_STAT    = 4'd9;

    // Slew select comes out of reset with every pin in the same state.
    localparam logic [7:0] GPIO_SL_RST  = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/hachure_wb_gpio_if.sv
`default_nettype none
// ============================================================================
// Module      : hachure_wb_gpio_if
// Description : Wishbone-classic slave bus bundle for the GPIO peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
interface hachure_wb_gpio_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );

endinterface
`default_nettype wire

// File: rtl/hachure_sync2.sv
`default_nettype none
// ============================================================================
// Module      : hachure_sync2
// Description : Parameterised-width two-flop synchroniser, sync reset.
// Revision    : 1.0 - initial release
// ============================================================================
module hachure_sync2 #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule
`default_nettype wire

// File: rtl/hachure_wb_gpio.sv
`default_nettype none
// ============================================================================
// Module      : hachure_wb_gpio
// Description : Wishbone GPIO slave with pad control, edge capture and IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module hachure_wb_gpio
    import hachure_pkg::*;
#(
    parameter int NUM_GPIO = 4
) (
    input  wire logic                clk_i,
    input  wire logic                rst_i,
    hachure_wb_gpio_if.slave         wb,
    input  wire logic [NUM_GPIO-1:0] gpi_i,
    output logic      [NUM_GPIO-1:0] gpo_o,
    output logic      [NUM_GPIO-1:0] gpeo_o,
    output logic      [NUM_GPIO-1:0] gpcs_o,
    output logic      [NUM_GPIO-1:0] gpsl_o,
    output logic      [NUM_GPIO-1:0] gppu_o,
    output logic      [NUM_GPIO-1:0] gppd_o,
    output logic                     irq_o
);

    localparam int         c_pad     = 32 - NUM_GPIO;
    localparam logic [1:0] c_warm_ok = 2'd3;

    logic [NUM_GPIO-1:0] r_gpo, r_gpeo, r_gpcs, r_gpsl, r_gppu, r_gppd;
    logic [NUM_GPIO-1:0] r_rise_en, r_fall_en, r_stat, r_prev;
    logic [1:0]          r_warm;
    logic                r_ack;
    logic                r_irq;
    logic [31:0]         r_dat;

    logic                w_req;
    logic                w_wr;
    logic [NUM_GPIO-1:0] w_wdata;
    logic [NUM_GPIO-1:0] w_sync;
    logic [NUM_GPIO-1:0] w_rise, w_fall, w_clr, w_stat_next;
    logic [NUM_GPIO-1:0] w_rsel;
    logic [31:0]         w_rdata;
    logic                w_unused;

    hachure_sync2 #(
        .WIDTH (NUM_GPIO)
    ) u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .i_d (gpi_i),
        .o_q (w_sync)
    );

    assign w_req   = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    assign w_wr    = w_req & wb.wb_we_i & wb.wb_sel_i[0];
    assign w_wdata = wb.wb_dat_i[NUM_GPIO-1:0];

    // Edges are masked until the sync chain and prev flop hold real pad data.
    assign w_rise = (r_warm == c_warm_ok) ? ( w_sync & ~r_prev) : '0;
    assign w_fall = (r_warm == c_warm_ok) ? (~w_sync &  r_prev) : '0;

    assign w_clr       = (w_wr && wb.wb_adr_i == GPIO_STAT) ? w_wdata : '0;
    assign w_stat_next = (r_stat & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);

    always_comb begin
        w_rsel = '0;
        case (wb.wb_adr_i)
            GPIO_OUT:     w_rsel = r_gpo;
            GPIO_OE:      w_rsel = r_gpeo;
            GPIO_IN:      w_rsel = w_sync;
            GPIO_CS:      w_rsel = r_gpcs;
            GPIO_SL:      w_rsel = r_gpsl;
            GPIO_PU:      w_rsel = r_gppu;
            GPIO_PD:      w_rsel = r_gppd;
            GPIO_RISE_EN: w_rsel = r_rise_en;
            GPIO_FALL_EN: w_rsel = r_fall_en;
            GPIO_STAT:    w_rsel = r_stat;
            default:      w_rsel = '0;
        endcase
    end

    assign w_rdata = {{c_pad{1'b0}}, w_rsel};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gpo     <= '0;
            r_gpeo    <= '0;
            r_gpcs    <= '0;
            r_gpsl    <= GPIO_SL_RST[NUM_GPIO-1:0];
            r_gppu    <= '0;
            r_gppd    <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_stat    <= '0;
            r_prev    <= '0;
            r_warm    <= 2'd0;
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req && !wb.wb_we_i) begin
                r_dat <= w_rdata;
            end
            if (w_wr) begin
                case (wb.wb_adr_i)
                    GPIO_OUT:     r_gpo     <= w_wdata;
                    GPIO_OE:      r_gpeo    <= w_wdata;
                    GPIO_CS:      r_gpcs    <= w_wdata;
                    GPIO_SL:      r_gpsl    <= w_wdata;
                    GPIO_PU:      r_gppu    <= w_wdata;
                    GPIO_PD:      r_gppd    <= w_wdata;
                    GPIO_RISE_EN: r_rise_en <= w_wdata;
                    GPIO_FALL_EN: r_fall_en <= w_wdata;
                    default:      ;
                endcase
            end
            r_prev <= w_sync;
            if (r_warm != c_warm_ok) begin
                r_warm <= r_warm + 2'd1;
            end
            r_stat <= w_stat_next;
            r_irq  <= |w_stat_next;
        end
    end

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat;
    assign gpo_o       = r_gpo;
    assign gpeo_o      = r_gpeo;
    assign gpcs_o      = r_gpcs;
    assign gpsl_o      = r_gpsl;
    assign gppu_o      = r_gppu;
    assign gppd_o      = r_gppd;
    assign irq_o       = r_irq;

    assign w_unused = &{1'b0, wb.wb_sel_i[3:1], wb.wb_dat_i[31:NUM_GPIO]};

endmodule
`default_nettype wire
